// File: rtl/video_line_fetch_if.sv
// Display-path bus bundle for video_line_fetch.
// Carries the VRAM read channel (req/addr/ack/data) and the line-buffer write channel.
//   master : the line fetcher (drives vram_req/vram_addr and the lb_* write port)
//   slave  : VRAM arbiter + line buffer (drives vram_ack/vram_data)
interface video_line_fetch_if #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned LB_HALF_W = 8
);
   logic              vram_req;
   logic [ADDR_W-1:0] vram_addr;
   logic              vram_ack;
   logic [15:0]       vram_data;
   logic              lb_we;
   logic [LB_HALF_W:0] lb_addr;
   logic [15:0]       lb_data;

   modport master (
      output vram_req, vram_addr, lb_we, lb_addr, lb_data,
      input  vram_ack, vram_data
   );

   modport slave (
      input  vram_req, vram_addr, lb_we, lb_addr, lb_data,
      output vram_ack, vram_data
   );
endinterface

// File: rtl/video_line_fetch.sv
// Per-scanline VRAM fetch scheduler.
// Prefetches the next display line into one half of a ping-pong line buffer while
// the pixel pipeline reads the other half (disp_buf_o).
// Ports:
//   clk, reset_n_i          pixel clock, synchronous active-low reset
//   enable_i                fetch enable (strobes still steer disp_buf_o when low)
//   line_base_i/_stride_i   line 0 address (sampled at end_of_visible_i), line pitch
//   fetch_words_i           words per line, 0..2**LB_HALF_W
//   visible_lines_i         visible lines per frame
//   end_of_*_i              video timing strobes
//   vbus                    VRAM read channel + line-buffer write channel (master)
//   disp_buf_o, busy_o      displayed half, fetch in progress
//   line_done_o             pulse with the final line-buffer write of a line
//   underrun_o              sticky: a fill was retriggered before completing
//   clear_status_i          clears underrun_o
module video_line_fetch #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned LB_HALF_W = 8,
   parameter int unsigned LINES_W   = 10
) (
   input  logic                 clk,
   input  logic                 reset_n_i,
   input  logic                 enable_i,
   input  logic [ADDR_W-1:0]    line_base_i,
   input  logic [ADDR_W-1:0]    line_stride_i,
   input  logic [LB_HALF_W:0]   fetch_words_i,
   input  logic [LINES_W-1:0]   visible_lines_i,
   input  logic                 end_of_line_i,
   input  logic                 end_of_visible_i,
   input  logic                 end_of_frame_i,
   video_line_fetch_if.master   vbus,
   output logic                 disp_buf_o,
   output logic                 busy_o,
   output logic                 line_done_o,
   output logic                 underrun_o,
   input  logic                 clear_status_i
);
   localparam int unsigned IDX_W = LB_HALF_W + 1;

   typedef enum logic {ST_IDLE, ST_FETCH} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0]  line_addr, line_addr_nxt;
   logic [LINES_W-1:0] lines_fetched, lines_nxt;
   logic               disp_buf, disp_nxt;
   logic [ADDR_W-1:0]  vram_addr;
   logic [IDX_W-1:0]   word_idx;
   logic [IDX_W-1:0]   fetch_len;
   logic               fill_half;
   logic               lb_we;
   logic [IDX_W-1:0]   lb_addr;
   logic [15:0]        lb_data;
   logic               line_done;
   logic               underrun;

   logic fill_go, fill_hf, done_nxt, under_set;
   logic ack_now, last_ack;

   assign ack_now  = (state == ST_FETCH) && vbus.vram_ack;
   assign last_ack = ack_now && (word_idx == fetch_len - IDX_W'(1));

   always_comb begin
      state_nxt     = state;
      disp_nxt      = disp_buf;
      line_addr_nxt = line_addr;
      lines_nxt     = lines_fetched;
      fill_go       = 1'b0;
      fill_hf       = 1'b0;
      done_nxt      = 1'b0;
      under_set     = 1'b0;

      // Displayed half follows the strobes regardless of enable.
      if (!end_of_visible_i) begin
         if (end_of_frame_i)     disp_nxt = 1'b0;
         else if (end_of_line_i) disp_nxt = ~disp_buf;
      end

      // lines_fetched counts lines already fetched this frame; the end-of-frame
      // fill brings in line 1, so it advances the count as well.
      if (enable_i) begin
         if (end_of_visible_i) begin
            line_addr_nxt = line_base_i;
            lines_nxt     = LINES_W'(1);
            fill_go       = 1'b1;
            fill_hf       = 1'b0;
         end else if (end_of_frame_i) begin
            line_addr_nxt = line_addr + line_stride_i;
            if (visible_lines_i > LINES_W'(1)) begin
               fill_go   = 1'b1;
               fill_hf   = 1'b1;
               lines_nxt = lines_fetched + LINES_W'(1);
            end
         end else if (end_of_line_i && (lines_fetched < visible_lines_i)) begin
            line_addr_nxt = line_addr + line_stride_i;
            fill_go       = 1'b1;
            fill_hf       = disp_buf;      // == ~new disp_buf
            lines_nxt     = lines_fetched + LINES_W'(1);
         end
      end

      case (state)
         ST_IDLE: begin
            if (fill_go && (fetch_words_i != '0)) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (!enable_i) begin
               state_nxt = ST_IDLE;
            end else if (fill_go) begin
               // A trigger coinciding with the final ack is a completed line, not an underrun.
               under_set = !last_ack;
               state_nxt = (fetch_words_i != '0) ? ST_FETCH : ST_IDLE;
            end else if (last_ack) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      done_nxt = enable_i && (last_ack || (fill_go && (fetch_words_i == '0)));
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state         <= ST_IDLE;
         line_addr     <= '0;
         lines_fetched <= '0;
         disp_buf      <= 1'b0;
         vram_addr     <= '0;
         word_idx      <= '0;
         fetch_len     <= '0;
         fill_half     <= 1'b0;
         lb_we         <= 1'b0;
         lb_addr       <= '0;
         lb_data       <= '0;
         line_done     <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         state         <= state_nxt;
         line_addr     <= line_addr_nxt;
         lines_fetched <= lines_nxt;
         disp_buf      <= disp_nxt;
         line_done     <= done_nxt;
         underrun      <= under_set | (underrun & ~clear_status_i);

         // Write pipeline uses the pre-trigger half/index, so an ack in a
         // retrigger cycle still lands where it belongs.
         lb_we <= ack_now;
         if (ack_now) begin
            lb_addr <= {fill_half, word_idx[LB_HALF_W-1:0]};
            lb_data <= vbus.vram_data;
         end

         if (fill_go) begin
            vram_addr <= line_addr_nxt;
            word_idx  <= '0;
            fetch_len <= fetch_words_i;
            fill_half <= fill_hf;
         end else if (ack_now) begin
            vram_addr <= vram_addr + ADDR_W'(1);
            word_idx  <= word_idx + IDX_W'(1);
         end
      end
   end

   assign vbus.vram_req  = (state == ST_FETCH);
   assign vbus.vram_addr = vram_addr;
   assign vbus.lb_we     = lb_we;
   assign vbus.lb_addr   = lb_addr;
   assign vbus.lb_data   = lb_data;
   assign busy_o         = (state == ST_FETCH);
   assign disp_buf_o     = disp_buf;
   assign line_done_o    = line_done;
   assign underrun_o     = underrun;
endmodule
